// File: rtl/pci_target_ctrl.sv
// PCI target sequencer: decodes config and four I/O BAR windows and runs a
// single-data-phase handshake (disconnect with data) on every accepted access.
module pci_target_ctrl #(
  parameter int IO_ADDR_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        idsel,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  input  logic [31:0] bar0,
  input  logic [31:0] bar1,
  input  logic [31:0] bar2,
  input  logic [31:0] bar3,
  input  logic        io_en,
  output logic        trdy_n,
  output logic        devsel_n,
  output logic        stop_n,
  output logic        ctl_oe,
  output logic        control,
  output logic        is_config_space,
  output logic        is_io_space0,
  output logic        is_io_space1,
  output logic        is_io_space2,
  output logic        is_io_space3,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic        rd_strobe,
  output logic        wr_strobe
);

  typedef enum logic [2:0] {IDLE, DECODE, RD_WAIT, DATA, TURN, BUSY} state_t;

  state_t      state, state_nx;
  logic [3:0]  cmd, cmd_nx;
  logic [4:0]  sel, sel_nx, sel_pick;  // bit0 = config, bit1+n = I/O window n
  logic [31:0] addr_nx;
  logic [3:0]  be_nx;
  logic        trdy_nx, devsel_nx, stop_nx, oe_nx, control_nx, rd_nx, wr_nx;
  logic [3:0][31:0] bar;
  logic [3:0]  io_hit;
  logic        io_cmd, cfg_cmd, unused_bar;

  assign bar        = {bar3, bar2, bar1, bar0};
  assign unused_bar = ^bar;
  assign io_cmd     = (cmd[3:1] == 3'b001);
  assign cfg_cmd    = (cmd[3:1] == 3'b101);

  always_comb begin
    for (int i = 0; i < 4; i++)
      io_hit[i] = io_en && bar[i][0] &&
                  (addr[31:IO_ADDR_BITS] == bar[i][31:IO_ADDR_BITS]);
  end

  // Fixed priority: config, then I/O window 0 down to 3; exactly one select.
  always_comb begin
    sel_pick = 5'b0;
    if (cfg_cmd && idsel && addr[1:0] == 2'b00) sel_pick = 5'b00001;
    else if (io_cmd && io_hit[0])               sel_pick = 5'b00010;
    else if (io_cmd && io_hit[1])               sel_pick = 5'b00100;
    else if (io_cmd && io_hit[2])               sel_pick = 5'b01000;
    else if (io_cmd && io_hit[3])               sel_pick = 5'b10000;
  end

  always_comb begin
    state_nx   = state;
    cmd_nx     = cmd;
    sel_nx     = sel;
    addr_nx    = addr;
    be_nx      = be;
    trdy_nx    = trdy_n;
    devsel_nx  = devsel_n;
    stop_nx    = stop_n;
    oe_nx      = ctl_oe;
    control_nx = control;
    rd_nx      = 1'b0;
    wr_nx      = 1'b0;
    case (state)
      IDLE: if (!frame_n) begin
        addr_nx  = ad_in;
        cmd_nx   = cbe_n;
        state_nx = DECODE;
      end
      DECODE: begin
        if (|sel_pick) begin
          sel_nx    = sel_pick;
          devsel_nx = 1'b0;
          oe_nx     = 1'b1;
          if (!cmd[0]) begin
            // Read: one edge of slack so the mux can register read data.
            control_nx = 1'b0;
            state_nx   = RD_WAIT;
          end else begin
            trdy_nx  = 1'b0;
            stop_nx  = 1'b0;
            state_nx = DATA;
          end
        end else begin
          state_nx = BUSY;
        end
      end
      RD_WAIT: begin
        trdy_nx  = 1'b0;
        stop_nx  = 1'b0;
        state_nx = DATA;
      end
      DATA: if (!irdy_n) begin
        be_nx      = ~cbe_n;
        rd_nx      = ~cmd[0];
        wr_nx      = cmd[0];
        trdy_nx    = 1'b1;
        stop_nx    = 1'b1;
        devsel_nx  = 1'b1;
        control_nx = 1'b1;
        state_nx   = TURN;
      end
      TURN: begin
        oe_nx    = 1'b0;
        sel_nx   = 5'b0;
        state_nx = (frame_n && irdy_n) ? IDLE : BUSY;
      end
      BUSY: if (frame_n && irdy_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= 4'b0;
      sel       <= 5'b0;
      addr      <= 32'b0;
      be        <= 4'b0;
      trdy_n    <= 1'b1;
      devsel_n  <= 1'b1;
      stop_n    <= 1'b1;
      ctl_oe    <= 1'b0;
      control   <= 1'b1;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd       <= cmd_nx;
      sel       <= sel_nx;
      addr      <= addr_nx;
      be        <= be_nx;
      trdy_n    <= trdy_nx;
      devsel_n  <= devsel_nx;
      stop_n    <= stop_nx;
      ctl_oe    <= oe_nx;
      control   <= control_nx;
      rd_strobe <= rd_nx;
      wr_strobe <= wr_nx;
    end
  end

  assign is_config_space = sel[0];
  assign is_io_space0    = sel[1];
  assign is_io_space1    = sel[2];
  assign is_io_space2    = sel[3];
  assign is_io_space3    = sel[4];

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl: completions are scoreboarded on the
// strobes, cycle-exact handshake timing is checked inline.
module tb_pci_target_ctrl;

  logic        clk = 1'b0, rst = 1'b1;
  logic        frame_n = 1'b1, irdy_n = 1'b1, idsel = 1'b0, io_en = 1'b0;
  logic [3:0]  cbe_n = 4'h0;
  logic [31:0] ad_in = 32'h0, bar0 = 32'h0, bar1 = 32'h0, bar2 = 32'h0, bar3 = 32'h0;
  logic        trdy_n, devsel_n, stop_n, ctl_oe, control;
  logic        is_config_space, is_io_space0, is_io_space1, is_io_space2, is_io_space3;
  logic [31:0] addr;
  logic [3:0]  be;
  logic        rd_strobe, wr_strobe;

  int tests = 0, fails = 0;

  // sel encoding: bit0 config, bit1..4 I/O window 0..3
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [4:0]  sel;
  } exp_t;
  exp_t q[$];

  pci_target_ctrl #(.IO_ADDR_BITS(3)) dut (
    .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .idsel(idsel),
    .cbe_n(cbe_n), .ad_in(ad_in), .bar0(bar0), .bar1(bar1), .bar2(bar2),
    .bar3(bar3), .io_en(io_en), .trdy_n(trdy_n), .devsel_n(devsel_n),
    .stop_n(stop_n), .ctl_oe(ctl_oe), .control(control),
    .is_config_space(is_config_space), .is_io_space0(is_io_space0),
    .is_io_space1(is_io_space1), .is_io_space2(is_io_space2),
    .is_io_space3(is_io_space3), .addr(addr), .be(be),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] sels();
    return {is_io_space3, is_io_space2, is_io_space1, is_io_space0, is_config_space};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the oldest expected completion.
  always @(negedge clk) begin
    if (rd_strobe || wr_strobe) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: rd=%0b wr=%0b addr=%0h", rd_strobe, wr_strobe, addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_rd", rd_strobe, e.rd);
        chk("sb_wr", wr_strobe, e.wr);
        chk("sb_be", be, e.be);
        chk("sb_addr", addr, e.addr);
        chk("sb_sel", sels(), e.sel);
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ctl", {trdy_n, devsel_n, stop_n, ctl_oe, control}, 5'b11101);
    chk("rst_sel", sels(), 5'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_be_strb", {be, rd_strobe, wr_strobe}, 6'b0);
    rst = 1'b0;

    // IO read hit, window 1
    bar1 = 32'h0000_0301; io_en = 1'b1;
    frame_n = 1'b0; ad_in = 32'h0000_0304; cbe_n = 4'b0010; idsel = 1'b0;
    tick();                                   // E0
    chk("rd_e0_addr", addr, 32'h0000_0304);
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'b1100;
    q.push_back('{rd:1'b1, wr:1'b0, be:4'h3, addr:32'h304, sel:5'b00100});
    tick();                                   // E1
    chk("rd_e1_sel", sels(), 5'b00100);
    chk("rd_e1_ctl", {control, devsel_n, ctl_oe, trdy_n, stop_n}, 5'b00111);
    tick();                                   // E2
    chk("rd_e2_ctl", {control, devsel_n, trdy_n, stop_n}, 4'b0000);
    tick();                                   // E3 completion
    chk("rd_e3_strb", rd_strobe, 1'b1);
    chk("rd_e3_rel", {control, devsel_n, trdy_n, stop_n, ctl_oe}, 5'b11111);
    irdy_n = 1'b1;
    tick();                                   // TURN
    chk("rd_turn", {ctl_oe, sels(), rd_strobe}, 7'b0);

    // Config write
    idsel = 1'b1; frame_n = 1'b0; ad_in = 32'h0000_0010; cbe_n = 4'b1011;
    tick();
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'b0000;
    q.push_back('{rd:1'b0, wr:1'b1, be:4'hF, addr:32'h10, sel:5'b00001});
    tick();                                   // E1
    chk("cw_e1_sel", sels(), 5'b00001);
    chk("cw_e1_ctl", {control, devsel_n, trdy_n, stop_n, ctl_oe}, 5'b10001);
    tick();                                   // E2
    chk("cw_e2", {wr_strobe, be, control}, 6'b1_1111_1);
    irdy_n = 1'b1; idsel = 1'b0;
    tick();
    chk("cw_turn", {ctl_oe, control, sels()}, 7'b0100000);

    // Overlapping BARs: window 0 wins over window 2
    bar0 = 32'h0000_0201; bar2 = 32'h0000_0201;
    frame_n = 1'b0; ad_in = 32'h0000_0200; cbe_n = 4'b0011;
    tick();
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'b1110;
    q.push_back('{rd:1'b0, wr:1'b1, be:4'h1, addr:32'h200, sel:5'b00010});
    tick();
    chk("ov_sel", sels(), 5'b00010);
    tick();
    irdy_n = 1'b1;
    tick();

    // Miss: matching BAR but I/O space disabled
    io_en = 1'b0; bar0 = 32'h0000_0501;
    frame_n = 1'b0; ad_in = 32'h0000_0500; cbe_n = 4'b0010;
    tick();
    frame_n = 1'b1; irdy_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("miss_quiet", {devsel_n, trdy_n, stop_n, ctl_oe, control, sels()}, 10'b11101_00000);
    end
    irdy_n = 1'b1;
    tick();                                   // BUSY -> IDLE

    // Master wait states on an I/O write; also proves return to IDLE
    io_en = 1'b1;
    frame_n = 1'b0; ad_in = 32'h0000_0504; cbe_n = 4'b0011;
    tick();
    chk("mw_e0_addr", addr, 32'h0000_0504);
    frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'b0101;
    tick();                                   // E1
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mw_hold", {trdy_n, stop_n, devsel_n, wr_strobe}, 4'b0000);
    end
    irdy_n = 1'b0;
    q.push_back('{rd:1'b0, wr:1'b1, be:4'hA, addr:32'h504, sel:5'b00010});
    tick();
    chk("mw_strb", {wr_strobe, trdy_n}, 2'b11);
    irdy_n = 1'b1;
    tick();

    // Async reset while in RD_WAIT
    frame_n = 1'b0; ad_in = 32'h0000_0300; cbe_n = 4'b0010;
    tick();
    frame_n = 1'b1; irdy_n = 1'b0;
    tick();                                   // E1 -> RD_WAIT
    chk("ar_pre", {control, is_io_space1}, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("ar_async", {control, devsel_n, ctl_oe, sels()}, 8'b110_00000);
    chk("ar_addr", addr, 32'h0);
    irdy_n = 1'b1;
    #1 rst = 1'b0;
    tick();
    frame_n = 1'b0; ad_in = 32'h0000_0304; cbe_n = 4'b0010;
    tick();
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'b0000;
    q.push_back('{rd:1'b1, wr:1'b0, be:4'hF, addr:32'h304, sel:5'b00100});
    tick();
    chk("ar_next_sel", {sels(), control}, 6'b00100_0);
    tick();
    tick();
    irdy_n = 1'b1;
    tick();
    tick();

    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pci_target_ctrl.md
Name: pci_target_ctrl

Overview:
- PCI target-side bus sequencer that sits directly upstream of the AD-bus data mux/register stage.
- Samples FRAME#/IRDY#/IDSEL/C/BE#/AD, decodes configuration and four I/O BAR windows, and drives TRDY#/DEVSEL#/STOP#.
- Generates the one-hot space selects (is_config_space, is_io_space0..3) and the AD direction control consumed by the mux stage, plus address, byte-enable and strobe outputs for the config-register file and the I/O devices.
- Every transaction is single-data-phase: disconnect-with-data on each access.

Parameters:
- IO_ADDR_BITS, 3, log2 of I/O window size in bytes; BAR compare uses ad[31:IO_ADDR_BITS].

Ports:
- clk  in  1  PCI clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_n  in  1  PCI FRAME#.
- irdy_n  in  1  PCI IRDY#.
- idsel  in  1  PCI IDSEL.
- cbe_n  in  4  PCI C/BE#.
- ad_in  in  32  PCI AD as sampled from the pad.
- bar0..bar3  in  32 each  I/O base addresses from the config registers; bit0 = 1 means enabled.
- io_en  in  1  Command register I/O Space enable.
- trdy_n, devsel_n, stop_n  out  1 each  Target control signals.
- ctl_oe  out  1  Output enable for trdy_n/devsel_n/stop_n pads.
- control  out  1  AD direction; 0 = drive AD (read data phase), 1 = pass bus to devices.
- is_config_space, is_io_space0..3  out  1 each  One-hot space selects.
- addr  out  32  Latched transaction address.
- be  out  4  Active-high byte enables, latched in the data phase.
- rd_strobe, wr_strobe  out  1 each  One-cycle completion pulses.

Behaviour:
- Reset (async): state IDLE; trdy_n = devsel_n = stop_n = 1; ctl_oe = 0; control = 1; all selects = 0; addr = 0; be = 0; strobes = 0.
- All outputs are registered.
- Accepted commands: 0010 IO read, 0011 IO write, 1010 cfg read, 1011 cfg write. All other commands are ignored.
- Edge E0, IDLE with frame_n == 0: latch addr <= ad_in and the command; go to DECODE.
- Edge E1, DECODE, hit evaluation:
  - Config hit: idsel == 1 and addr[1:0] == 00.
  - I/O hit n: io_en == 1, barn[0] == 1, and addr[31:IO_ADDR_BITS] == barn[31:IO_ADDR_BITS].
  - Priority among I/O hits: device0 > 1 > 2 > 3. Only one select is asserted.
- E1, hit: set the single select; devsel_n = 0; ctl_oe = 1.
  - Read: control = 0; go to RD_WAIT. This gives the mux one edge to register data.
  - Write: trdy_n = 0 and stop_n = 0; go to DATA.
- E1, miss or unsupported command: go to BUSY with no outputs changed (master abort is the master's concern).
- E2, RD_WAIT: trdy_n = 0, stop_n = 0; go to DATA.
- DATA, with irdy_n sampled 0:
  - Capture be <= ~cbe_n.
  - Pulse rd_strobe or wr_strobe for exactly one cycle.
  - Deassert trdy_n, stop_n and devsel_n (drive high); control = 1; go to TURN.
- DATA, with irdy_n == 1: hold the state indefinitely; there is no timeout.
- TURN: exactly one cycle.
  - ctl_oe = 0 and all selects = 0.
  - Next state: IDLE if frame_n == 1 and irdy_n == 1, else BUSY.
- BUSY: wait until frame_n == 1 and irdy_n == 1, then go to IDLE. Back-to-back: a new frame_n == 0 in IDLE on the next edge is accepted.
- addr holds its value until the next E0.
- be holds its value until the next data-phase capture.
- control == 0 only from E1 through the completion edge of a read. It is never 0 during writes or in IDLE.
- Reset asserted mid-transaction returns all outputs to reset values immediately, without waiting for a clock.

Test Plan:
- IO read hit, device1 (bar1 = 0x0000_0301, io_en = 1, ad = 0x0000_0304, cbe_n = 0010, IDSEL = 0, irdy_n low at E1) -> is_io_space1 = 1 and control = 0 at E1; devsel_n low from E1; trdy_n = stop_n = 0 at E2; rd_strobe one cycle at E3; all released and ctl_oe = 0 after TURN.
- Config write (idsel = 1, ad = 0x0000_0010, cbe_n = 1011, then 0000 in the data phase, irdy_n low) -> is_config_space = 1 at E1; trdy_n = 0 at E1; wr_strobe and be = 4'hF at E2; control stays 1 throughout.
- Overlapping BARs (bar0 = bar2 = 0x0000_0201, ad = 0x0000_0200) -> only is_io_space0 = 1.
- Miss (ad = 0x0000_0500, io_en = 0 with a matching BAR) -> devsel_n, trdy_n and ctl_oe never assert; return to IDLE after frame_n/irdy_n are high.
- Master wait: irdy_n held high 5 cycles in DATA -> trdy_n holds 0, no strobe; strobe on the first edge irdy_n = 0.
- Reset asserted in RD_WAIT -> control = 1, devsel_n = 1, selects = 0 with no clock edge; the next transaction decodes normally.
